if_fetch_stage: RTL
===================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage feeding the IF/ID pipeline register.
//  - Owns the PC and drives a req/ack instruction-memory port.
//  - Produces {PC+4, instr} with write-enable and flush controls for IF/ID.
//  - Handles load-use stalls from the hazard unit and branch/jump redirects resolved downstream.
// PARAMETERS
//  ADDR_W    32       PC / memory address width
//  INSTR_W   32       instruction width
//  RESET_PC  32'h0    PC value loaded on reset
// PORTS
//  clk_i          in   1                 clock, all state on posedge
//  rst_i          in   1                 asynchronous active-low reset
//  stall_i        in   1                 hold IF/ID and PC (hazard unit)
//  redirect_i     in   1                 taken branch/jump; kill fetch path
//  redirect_pc_i  in   ADDR_W            redirect target
//  imem_req_o     out  1                 fetch request
//  imem_addr_o    out  ADDR_W            fetch address
//  imem_ack_i     in   1                 imem_data_i valid this cycle
//  imem_data_i    in   INSTR_W           fetched instruction
//  ifid_data_o    out  ADDR_W+INSTR_W    {pc+4, instr} to IF/ID data input
//  ifid_valid_o   out  1                 IF/ID write enable
//  ifid_flush_o   out  1                 IF/ID flush (inserts bubble)
//  busy_o         out  1                 fetch outstanding (FETCH or DISCARD)
// BEHAVIOUR
//  State: pc_q[ADDR_W], buf_q[INSTR_W], st_q in {FETCH, HOLD, DISCARD}.
//  Reset (rst_i=0, async): st_q=FETCH, pc_q=RESET_PC, buf_q=0; all outputs 0
//   while rst_i low. First request is issued in the first cycle after release.
//   Reset mid-transaction abandons it; imem shares the reset.
//  imem protocol: req held high with stable addr until ack; 1-cycle ack pulse;
//   latency >=0 cycles (ack may arrive in the request cycle).
//  FETCH: req=1, addr=pc_q.
//   redirect_i & ack  -> drop data, pc_q<=redirect_pc_i, stay FETCH.
//   redirect_i & ~ack -> pc_q<=redirect_pc_i, go DISCARD (addr stays old PC via saved copy).
//   ack & stall_i     -> buf_q<=imem_data_i, go HOLD.
//   ack (no stall)    -> deliver imem_data_i, pc_q<=pc_q+4.
//  DISCARD: req=1, addr=abandoned PC. ack -> drop data, go FETCH.
//   Further redirect_i updates pc_q (last wins), stays DISCARD until ack.
//  HOLD: req=0. redirect_i -> drop buf_q, pc_q<=redirect_pc_i, go FETCH.
//   ~stall_i -> deliver buf_q, pc_q<=pc_q+4, go FETCH. else stay.
//  Priority: redirect_i > stall_i > ack.
//  Outputs (combinational from state + inputs, same-cycle):
//   deliver      = fresh instr handed over this cycle (cases above).
//   ifid_valid_o = ~stall_i | redirect_i.
//   ifid_flush_o = ifid_valid_o & ~deliver (bubble on redirect or fetch miss).
//   ifid_data_o  = {pc_q+4, delivered instr}; 0 when ~deliver.
//  PC arithmetic: modulo 2^ADDR_W; wrap from all-ones-3 to 0 is silent.
//  No instruction is ever delivered twice or skipped; at most one fetch outstanding.
// CONFIGURATION
//  IF_BUBBLE_CNT_EN defined: adds output bubble_cnt_o [31:0]; +1 each cycle
//   ifid_flush_o=1; saturates at 32'hFFFF_FFFF; async-reset to 0.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  1 zero-latency imem (ack same cycle), RESET_PC=0x100 -> IF/ID gets 0x104,0x108,...
//    one per cycle, flush never high after first delivery.
//  2 imem latency 2 -> each instr preceded by 2 cycles valid=1,flush=1; pc_q steps by 4.
//  3 stall_i high 3 cycles on ack of 0x200 -> HOLD, valid=0, req=0;
//    on release instr delivered with data {0x204,instr}, next addr 0x204.
//  4 redirect_i to 0x400 while ack pending (latency 3) -> DISCARD, late ack dropped,
//    next req addr 0x400, flush=1 every cycle until 0x400 delivered.
//  5 redirect_i and stall_i same cycle in HOLD -> valid=1, flush=1, buf dropped,
//    next addr = redirect target; rst_i low mid-fetch -> req=0 at once, restart at RESET_PC.
//  6 IF_BUBBLE_CNT_EN: scenario 2 for 4 instr -> bubble_cnt_o counts 8 (+1 reset-exit cycle if applicable).

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the req/ack imem port and feeds IF/ID.
// Optional IF_BUBBLE_CNT_EN adds bubble_cnt_o, a saturating count of IF/ID flush cycles.
module if_fetch_stage #(
    parameter int               ADDR_W   = 32,
    parameter int               INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      stall_i,
    input  logic                      redirect_i,
    input  logic [ADDR_W-1:0]         redirect_pc_i,
    output logic                      imem_req_o,
    output logic [ADDR_W-1:0]         imem_addr_o,
    input  logic                      imem_ack_i,
    input  logic [INSTR_W-1:0]        imem_data_i,
    output logic [ADDR_W+INSTR_W-1:0] ifid_data_o,
    output logic                      ifid_valid_o,
    output logic                      ifid_flush_o,
    output logic                      busy_o
`ifdef IF_BUBBLE_CNT_EN
    ,
    output logic [31:0]               bubble_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_disc_addr;
    logic [INSTR_W-1:0]  r_buf;

    state_t              w_state_nx;
    logic [ADDR_W-1:0]   w_pc_nx;
    logic [ADDR_W-1:0]   w_disc_addr_nx;
    logic [INSTR_W-1:0]  w_buf_nx;
    logic [ADDR_W-1:0]   w_pc_plus4;
    logic                w_req;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_deliver;
    logic [INSTR_W-1:0]  w_instr;
    logic                w_valid;

    assign w_pc_plus4 = r_pc + ADDR_W'(4);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nx     = r_state;
        w_pc_nx        = r_pc;
        w_disc_addr_nx = r_disc_addr;
        w_buf_nx       = r_buf;
        w_req          = 1'b0;
        w_addr         = r_pc;
        w_deliver      = 1'b0;
        w_instr        = '0;

        unique case (r_state)
            ST_FETCH: begin
                w_req = 1'b1;
                if (redirect_i) begin
                    w_pc_nx = redirect_pc_i;
                    if (!imem_ack_i) begin
                        // The abandoned request must keep its address until its ack.
                        w_state_nx     = ST_DISCARD;
                        w_disc_addr_nx = r_pc;
                    end
                end else if (imem_ack_i && stall_i) begin
                    w_buf_nx   = imem_data_i;
                    w_state_nx = ST_HOLD;
                end else if (imem_ack_i) begin
                    w_deliver = 1'b1;
                    w_instr   = imem_data_i;
                    w_pc_nx   = w_pc_plus4;
                end
            end
            ST_DISCARD: begin
                w_req  = 1'b1;
                w_addr = r_disc_addr;
                if (redirect_i) begin
                    w_pc_nx = redirect_pc_i;
                end
                if (imem_ack_i) begin
                    w_state_nx = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (redirect_i) begin
                    w_pc_nx    = redirect_pc_i;
                    w_state_nx = ST_FETCH;
                end else if (!stall_i) begin
                    w_deliver  = 1'b1;
                    w_instr    = r_buf;
                    w_pc_nx    = w_pc_plus4;
                    w_state_nx = ST_FETCH;
                end
            end
            default: begin
                w_state_nx = ST_FETCH;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= ST_FETCH;
            r_pc        <= RESET_PC;
            r_disc_addr <= '0;
            r_buf       <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_pc        <= w_pc_nx;
            r_disc_addr <= w_disc_addr_nx;
            r_buf       <= w_buf_nx;
        end
    end

    // Outputs are gated by rst_i so an asserted reset silences the port immediately.
    assign w_valid      = rst_i & (~stall_i | redirect_i);
    assign imem_req_o   = rst_i & w_req;
    assign imem_addr_o  = rst_i ? w_addr : '0;
    assign ifid_valid_o = w_valid;
    assign ifid_flush_o = w_valid & ~(rst_i & w_deliver);
    assign ifid_data_o  = (rst_i && w_deliver) ? {w_pc_plus4, w_instr} : '0;
    assign busy_o       = rst_i & (r_state != ST_HOLD);

`ifdef IF_BUBBLE_CNT_EN
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_bubble_cnt <= '0;
        end else if (ifid_flush_o && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign bubble_cnt_o = r_bubble_cnt;
`endif

endmodule
